fir_result_checker: RTL and testbench

Hardware result checker for the FIR subsystem. After `fir_top` has written two output regions of the shared 8-bit sample memory (non-pipelined and pipelined runs), this block reads both regions back through a synchronous read port and compares them sample by sample. It reports the mismatch count, the first mismatching sample, and the elapsed cycles. Control uses the same start/done handshake as `fir_top`, so the same controller or bench drives both blocks.

---
 rtl/fir_result_checker_if.sv | 34 +++
 rtl/fir_result_checker.sv | 144 ++++++++++++++
 tb/tb_fir_result_checker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_result_checker_if.sv
// Start/done handshake, memory read port and result bus between a controller and fir_result_checker.
interface fir_result_checker_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] sample_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mismatch_count;
  logic              first_valid;
  logic [ADDR_W-1:0] first_idx;
  logic [DATA_W-1:0] first_a;
  logic [DATA_W-1:0] first_b;
  logic [31:0]       cycle_count;

  // Controller side; it also returns memory read data.
  modport master (
    output start, base_a, base_b, sample_count, mem_rdata,
    input  mem_rd_en, mem_addr, busy, done, mismatch_count,
           first_valid, first_idx, first_a, first_b, cycle_count
  );

  modport slave (
    input  start, base_a, base_b, sample_count, mem_rdata,
    output mem_rd_en, mem_addr, busy, done, mismatch_count,
           first_valid, first_idx, first_a, first_b, cycle_count
  );
endinterface

// File: rtl/fir_result_checker.sv
// Reads two sample regions back and compares them sample by sample, reporting mismatches and timing.
// Optional FIR_CHECK_TOLERANCE_EN: samples within +/-1 (signed) count as matching.
module fir_result_checker #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  fir_result_checker_if.slave bus
);
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CMP,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mismatch_q;
  logic [ADDR_W-1:0] first_idx_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] first_a_q;
  logic [DATA_W-1:0] first_b_q;
  logic              mem_rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic              first_valid_q;
  logic [CNT_W-1:0]  cycle_q;
  logic              match_c;
  logic              last_c;

`ifdef FIR_CHECK_TOLERANCE_EN
  // One extra bit keeps e.g. 127 - (-128) = 255 from wrapping into range.
  logic signed [DATA_W:0] diff_c;
  assign diff_c  = $signed({a_q[DATA_W-1], a_q}) - $signed({bus.mem_rdata[DATA_W-1], bus.mem_rdata});
  assign match_c = (diff_c == '0) || (diff_c == (DATA_W+1)'(1)) || (diff_c == '1);
`else
  assign match_c = (a_q == bus.mem_rdata);
`endif

  assign last_c = (idx_q == n_q - ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_a_q      <= '0;
      base_b_q      <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      mem_addr_q    <= '0;
      mismatch_q    <= '0;
      first_idx_q   <= '0;
      a_q           <= '0;
      first_a_q     <= '0;
      first_b_q     <= '0;
      mem_rd_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      first_valid_q <= 1'b0;
      cycle_q       <= '0;
    end else begin
      if ((state_q == S_RD_A || state_q == S_RD_B || state_q == S_CMP) && cycle_q != '1) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            base_a_q      <= bus.base_a;
            base_b_q      <= bus.base_b;
            n_q           <= bus.sample_count;
            idx_q         <= '0;
            mismatch_q    <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_a_q     <= '0;
            first_b_q     <= '0;
            cycle_q       <= '0;
            if (bus.sample_count != '0) begin
              state_q     <= S_RD_A;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= bus.base_a;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RD_A: begin
          state_q    <= S_RD_B;
          mem_addr_q <= base_b_q + idx_q;
        end
        S_RD_B: begin
          state_q     <= S_CMP;
          a_q         <= bus.mem_rdata;
          mem_rd_en_q <= 1'b0;
        end
        S_CMP: begin
          // Only the first mismatch of a run is captured.
          if (!match_c) begin
            mismatch_q <= mismatch_q + ADDR_W'(1);
            if (!first_valid_q) begin
              first_valid_q <= 1'b1;
              first_idx_q   <= idx_q;
              first_a_q     <= a_q;
              first_b_q     <= bus.mem_rdata;
            end
          end
          if (last_c) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_RD_A;
            idx_q       <= idx_q + ADDR_W'(1);
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= base_a_q + idx_q + ADDR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en      = mem_rd_en_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.first_valid    = first_valid_q;
  assign bus.first_idx      = first_idx_q;
  assign bus.first_a        = first_a_q;
  assign bus.first_b        = first_b_q;
  assign bus.cycle_count    = cycle_q;
endmodule

// File: tb/tb_fir_result_checker.sv
// Directed bench for fir_result_checker: timeline model of the compare run plus literal expectations.
module tb_fir_result_checker;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int MEM_SZ = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  fir_result_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [MEM_SZ];
  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int addr_log [$];

  // Synchronous read memory, data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      addr_log.push_back(int'(bus.mem_addr));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: t = cycles since the accepted start (t=1 is the first cycle after the accept edge).
  bit m_active = 1'b0;
  int m_t = 0, m_n = 0, m_ba = 0, m_bb = 0, m_hold = 0;
  bit m_mis [MEM_SZ];
  int m_va [MEM_SZ];
  int m_vb [MEM_SZ];

  function automatic int model_done_t();
    return 3 * m_n + 1;
  endfunction

  function automatic int model_addr();
    int p, j;
    if (!m_active) return 0;
    if (m_n == 0) return m_hold;
    if (m_t > 3 * m_n) return (m_bb + m_n - 1) % MEM_SZ;
    p = (m_t - 1) % 3;
    j = (m_t - 1) / 3;
    return (p == 0) ? (m_ba + j) % MEM_SZ : (m_bb + j) % MEM_SZ;
  endfunction

  function automatic bit sample_mismatch(input int a, input int b);
`ifdef FIR_CHECK_TOLERANCE_EN
    return (a - b > 1) || (b - a > 1);
`else
    return a != b;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (bus.start && (!m_active || m_t >= model_done_t())) begin
      m_hold = model_addr();
      m_ba = int'(bus.base_a);
      m_bb = int'(bus.base_b);
      m_n = int'(bus.sample_count);
      m_t = 1;
      m_active = 1'b1;
      for (int j = 0; j < m_n; j++) begin
        m_va[j] = int'($signed(mem[(m_ba + j) % MEM_SZ]));
        m_vb[j] = int'($signed(mem[(m_bb + j) % MEM_SZ]));
        m_mis[j] = sample_mismatch(m_va[j], m_vb[j]);
      end
    end else if (m_active && m_t < model_done_t()) begin
      m_t = m_t + 1;
    end
  end

  // Every cycle after reset: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      int k, mc, fi, cyc;
      bit fv, e_busy, e_done, e_rd;
      e_busy = m_active && m_n != 0 && m_t <= 3 * m_n;
      e_done = m_active && m_t >= model_done_t();
      e_rd = e_busy && ((m_t - 1) % 3 != 2);
      k = m_active ? (m_t - 1) / 3 : 0;
      if (k > m_n) k = m_n;
      cyc = m_active ? m_t - 1 : 0;
      if (cyc > 3 * m_n) cyc = 3 * m_n;
      mc = 0; fi = 0; fv = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (m_mis[j]) begin
          if (!fv) fi = j;
          fv = 1'b1;
          mc++;
        end
      end
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(e_rd));
      chk("mem_addr", 64'(bus.mem_addr), 64'(model_addr()));
      chk("mismatch_count", 64'(bus.mismatch_count), 64'(mc));
      chk("first_valid", 64'(bus.first_valid), 64'(fv));
      chk("first_idx", 64'(bus.first_idx), 64'(fi));
      chk("first_a", 64'(bus.first_a), fv ? 64'(m_va[fi] & 255) : 64'(0));
      chk("first_b", 64'(bus.first_b), fv ? 64'(m_vb[fi] & 255) : 64'(0));
      chk("cycle_count", 64'(bus.cycle_count), 64'(cyc));
    end
  end

  // Starts a run and counts cycles from the accept edge until done is seen.
  task automatic run(input int ba, input int bb, input int n, output int cyc);
    @(negedge clk);
    bus.base_a = ADDR_W'(ba);
    bus.base_b = ADDR_W'(bb);
    bus.sample_count = ADDR_W'(n);
    bus.start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
    end while (!bus.done && cyc < 4000);
    chk("done_reached", 64'(bus.done), 64'(1));
  endtask

  initial begin
    int cyc, lb;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.sample_count = '0;
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'(i * 37 + 11);
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_cycle", 64'(bus.cycle_count), 64'(0));
    rst = 1'b0;

    // Identical regions
    for (int j = 0; j < 100; j++) mem[612 + j] = mem[512 + j];
    run(512, 612, 100, cyc);
    chk("id_done_cycle", 64'(cyc), 64'(301));
    chk("id_mis", 64'(bus.mismatch_count), 64'(0));
    chk("id_fv", 64'(bus.first_valid), 64'(0));
    chk("id_cycles", 64'(bus.cycle_count), 64'(300));

    // Two mismatches, restart from DONE
    mem[519] = 8'h10;
    mem[619] = 8'h12;
    mem[652] = mem[552] ^ 8'h55;
    run(512, 612, 100, cyc);
    chk("mm_done_cycle", 64'(cyc), 64'(301));
    chk("mm_mis", 64'(bus.mismatch_count), 64'(2));
    chk("mm_idx", 64'(bus.first_idx), 64'(7));
    chk("mm_a", 64'(bus.first_a), 64'(8'h10));
    chk("mm_b", 64'(bus.first_b), 64'(8'h12));

    // Start while busy is ignored
    @(negedge clk);
    bus.sample_count = ADDR_W'(10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.sample_count = ADDR_W'(3);
    bus.base_a = ADDR_W'(0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_done", 64'(bus.done), 64'(1));
    chk("ign_cycles", 64'(bus.cycle_count), 64'(30));
    chk("ign_mis", 64'(bus.mismatch_count), 64'(1));

    // Zero samples
    run(5, 6, 0, cyc);
    chk("n0_done_cycle", 64'(cyc), 64'(1));
    chk("n0_mis", 64'(bus.mismatch_count), 64'(0));
    chk("n0_cycles", 64'(bus.cycle_count), 64'(0));
    chk("n0_rd_en", 64'(bus.mem_rd_en), 64'(0));

    // Address wrap-around in region A
    for (int j = 0; j < 8; j++) begin
      mem[(1020 + j) % MEM_SZ] = 8'(j * 3 + 1);
      mem[100 + j] = 8'(j * 3 + 1);
    end
    mem[1] = 8'h33;
    mem[105] = 8'h44;
    lb = addr_log.size();
    run(1020, 100, 8, cyc);
    chk("wr_reads", 64'(addr_log.size() - lb), 64'(16));
    chk("wr_addr0", 64'(addr_log[lb]), 64'(1020));
    chk("wr_addr6", 64'(addr_log[lb + 6]), 64'(1023));
    chk("wr_addr8", 64'(addr_log[lb + 8]), 64'(0));
    chk("wr_addr9", 64'(addr_log[lb + 9]), 64'(104));
    chk("wr_addr15", 64'(addr_log[lb + 15]), 64'(107));
    chk("wr_mis", 64'(bus.mismatch_count), 64'(1));
    chk("wr_idx", 64'(bus.first_idx), 64'(5));
    chk("wr_a", 64'(bus.first_a), 64'(8'h33));
    chk("wr_b", 64'(bus.first_b), 64'(8'h44));

    // Reset mid-compare, then a fresh run
    @(negedge clk);
    bus.base_a = ADDR_W'(512);
    bus.base_b = ADDR_W'(612);
    bus.sample_count = ADDR_W'(100);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", 64'(bus.busy), 64'(0));
    chk("mr_rd_en", 64'(bus.mem_rd_en), 64'(0));
    chk("mr_addr", 64'(bus.mem_addr), 64'(0));
    chk("mr_cycles", 64'(bus.cycle_count), 64'(0));
    run(512, 612, 100, cyc);
    chk("mr_final_cycles", 64'(bus.cycle_count), 64'(300));
    chk("mr_final_mis", 64'(bus.mismatch_count), 64'(2));

    // Tolerance pairs (5,4) and (127,-128)
    mem[200] = 8'd5;
    mem[300] = 8'd4;
    mem[201] = 8'h7F;
    mem[301] = 8'h80;
    run(200, 300, 2, cyc);
`ifdef FIR_CHECK_TOLERANCE_EN
    chk("tol_mis", 64'(bus.mismatch_count), 64'(1));
    chk("tol_idx", 64'(bus.first_idx), 64'(1));
    chk("tol_a", 64'(bus.first_a), 64'(8'h7F));
    chk("tol_b", 64'(bus.first_b), 64'(8'h80));
`else
    chk("tol_mis", 64'(bus.mismatch_count), 64'(2));
    chk("tol_idx", 64'(bus.first_idx), 64'(0));
    chk("tol_a", 64'(bus.first_a), 64'(5));
    chk("tol_b", 64'(bus.first_b), 64'(4));
`endif

    // Start and reset on the same edge: reset wins
    @(negedge clk);
    bus.sample_count = ADDR_W'(4);
    bus.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    chk("sr_busy", 64'(bus.busy), 64'(0));
    chk("sr_done", 64'(bus.done), 64'(0));
    chk("sr_mis", 64'(bus.mismatch_count), 64'(0));
    repeat (3) @(negedge clk);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
